// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port integer register file.
//   XLEN_DEF / NUM_REGS_DEF : default register width and architectural count
//   reg_addr_t / xword_t    : address and data types at the default sizes
//   ZERO_REG                : the hardwired-zero register (x0)
package reg_file_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write (busy) bit per register, used by decode to stall on RAW hazards.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   rs_addr   : packed read addresses, port p at [p*AW +: AW]
//   rs_busy   : per read port, register has an outstanding producer
//   rsv_en/rsv_addr : set busy for the destination of an issuing instruction
//   wr_en/wr_addr/wr_clr : writeback; wr_clr marks the final producer (clear busy)
//   flush     : clear every busy bit
//   any_busy  : OR of the stored busy bits
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int NUM_REGS     = NUM_REGS_DEF,
  parameter  int NUM_RD_PORTS = 2,
  parameter  int NUM_WR_PORTS = 2,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD_PORTS*AW-1:0] rs_addr,
  output logic [NUM_RD_PORTS-1:0]    rs_busy,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  input  logic [NUM_WR_PORTS-1:0]    wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0] wr_addr,
  input  logic [NUM_WR_PORTS-1:0]    wr_clr,
  input  logic                       flush,
  output logic                       any_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_vec;

  // Registers released by a final producer this cycle. Several ports hitting
  // the same register OR together, so any wr_clr among them clears it.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    clr_vec = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en[w] && wr_clr[w]) begin
        clr_vec[wr_addr[w*AW +: AW]] = 1'b1;
      end
    end
  end

  // Priority below reset: reserve > flush > clear > hold. The reserve is
  // applied last so a new producer supersedes a same-cycle clear or flush.
  always_comb begin
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~clr_vec;
    end
    if (rsv_en && (rsv_addr != AW'(ZERO_REG))) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read-side lookup: a same-cycle final write hides the stored busy bit;
  // a same-cycle reservation is deliberately not visible until next cycle.
  always_comb begin
    rs_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      logic [AW-1:0] a;
      logic          hit_clr;
      a       = rs_addr[p*AW +: AW];
      hit_clr = 1'b0;
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_en[w] && wr_clr[w] && (wr_addr[w*AW +: AW] == a)) begin
          hit_clr = 1'b1;
        end
      end
      rs_busy[p] = (a != AW'(ZERO_REG)) && !hit_clr && busy_q[a];
    end
  end

  assign any_busy = |busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_mp_sb.sv
// Multi-port integer register file with write-to-read bypass, hardwired x0
// and an integrated busy-bit scoreboard.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   rs_addr   : packed read addresses, port p at [p*AW +: AW]
//   rs_data   : packed combinational read data, port p at [p*XLEN +: XLEN]
//   rs_busy   : per read port, register has a pending producer
//   rsv_en/rsv_addr : reserve a destination at issue
//   wr_en/wr_addr/wr_data/wr_clr : write ports, higher index wins
//   flush     : clear all busy bits, data kept
//   any_busy  : OR of stored busy bits
module reg_file_mp_sb
  import reg_file_pkg::*;
#(
  parameter  int XLEN         = XLEN_DEF,
  parameter  int NUM_REGS     = NUM_REGS_DEF,
  parameter  int NUM_RD_PORTS = 2,
  parameter  int NUM_WR_PORTS = 2,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD_PORTS*AW-1:0]   rs_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0] rs_data,
  output logic [NUM_RD_PORTS-1:0]      rs_busy,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  input  logic [NUM_WR_PORTS-1:0]      wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]   wr_addr,
  input  logic [NUM_WR_PORTS*XLEN-1:0] wr_data,
  input  logic [NUM_WR_PORTS-1:0]      wr_clr,
  input  logic                         flush,
  output logic                         any_busy
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Ports are walked in ascending order so the highest-index port writing a
  // given register is the last assignment and therefore wins.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG))) begin
        regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage array is reset because the core relies on every
    // register reading as zero after reset, not only x0.
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux with bypass; same ascending-priority rule as the write path.
  always_comb begin
    rs_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] val;
      a   = rs_addr[p*AW +: AW];
      val = regs_q[a];
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == a)) begin
          val = wr_data[w*XLEN +: XLEN];
        end
      end
      if (a == AW'(ZERO_REG)) begin
        val = '0;
      end
      rs_data[p*XLEN +: XLEN] = val;
    end
  end

  reg_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .NUM_WR_PORTS (NUM_WR_PORTS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rs_busy  (rs_busy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .flush    (flush),
    .any_busy (any_busy)
  );

endmodule : reg_file_mp_sb

// File: tb/tb_reg_file_mp_sb.sv
// Directed bench for reg_file_mp_sb. Expected values are queued as each step
// is driven and popped against the DUT outputs after the inputs settle.
module tb_reg_file_mp_sb;
  import reg_file_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  typedef enum logic [1:0] {K_DATA, K_BUSY, K_ANY} kind_e;
  typedef struct {
    string  tag;
    kind_e  kind;
    int     port;
    xword_t exp;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_clr;
  logic                flush;
  logic                any_busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  reg_file_mp_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_clr   (wr_clr),
    .flush    (flush),
    .any_busy (any_busy)
  );

  task automatic idle();
    rst = 1'b0; rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
  endtask

  task automatic rd(input int p, input int a);
    rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int w, input int a, input xword_t d, input logic c);
    wr_en[w]              = 1'b1;
    wr_addr[w*AW +: AW]   = AW'(a);
    wr_data[w*XLEN +: XLEN] = d;
    wr_clr[w]             = c;
  endtask

  task automatic rsv(input int a);
    rsv_en   = 1'b1;
    rsv_addr = AW'(a);
  endtask

  task automatic expect_val(input string tag, input kind_e k, input int p, input xword_t e);
    exp_t item;
    item.tag = tag; item.kind = k; item.port = p; item.exp = e;
    exp_q.push_back(item);
  endtask

  // Let combinational outputs settle, then drain the scoreboard queue.
  task automatic check();
    exp_t   item;
    xword_t obs;
    #1;
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      case (item.kind)
        K_DATA:  obs = rs_data[item.port*XLEN +: XLEN];
        K_BUSY:  obs = {31'b0, rs_busy[item.port]};
        default: obs = {31'b0, any_busy};
      endcase
      n_checks++;
      assert (obs === item.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
    end
  endtask

  // Commit at the rising edge; next step is driven on the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rs_addr = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idle();

    // Reset state
    rd(0, 5); rd(1, 0);
    expect_val("rst_data", K_DATA, 0, 32'h0);
    expect_val("rst_busy", K_BUSY, 0, 32'h0);
    expect_val("rst_any",  K_ANY,  0, 32'h0);
    check(); cycle();

    // Write x5 with a reservation, then reset discards both
    wr(0, 5, 32'hDEADBEEF, 1'b0); rsv(5); rd(0, 5);
    expect_val("x5_bypass", K_DATA, 0, 32'hDEADBEEF);
    expect_val("x5_rsv_not_visible", K_BUSY, 0, 32'h0);
    check(); cycle();

    rd(0, 5); rst = 1'b1;
    expect_val("x5_stored", K_DATA, 0, 32'hDEADBEEF);
    expect_val("x5_busy",   K_BUSY, 0, 32'h1);
    expect_val("x5_any",    K_ANY,  0, 32'h1);
    check(); cycle();

    rd(0, 5);
    expect_val("x5_after_rst",   K_DATA, 0, 32'h0);
    expect_val("busy_after_rst", K_BUSY, 0, 32'h0);
    expect_val("any_after_rst",  K_ANY,  0, 32'h0);
    check(); cycle();

    // Bypass on port 1, write to x0 ignored
    wr(0, 7, 32'h12345678, 1'b0); wr(1, 0, 32'hFFFFFFFF, 1'b1);
    rd(0, 0); rd(1, 7);
    expect_val("x7_bypass",  K_DATA, 1, 32'h12345678);
    expect_val("x0_bypass",  K_DATA, 0, 32'h0);
    expect_val("x0_busy",    K_BUSY, 0, 32'h0);
    check(); cycle();

    rd(0, 0); rd(1, 7);
    expect_val("x0_stored", K_DATA, 0, 32'h0);
    expect_val("x7_stored", K_DATA, 1, 32'h12345678);
    check(); cycle();

    // Write-port priority
    wr(0, 3, 32'hAAAA0000, 1'b0); wr(1, 3, 32'h5555FFFF, 1'b0);
    rd(0, 3); rd(1, 3);
    expect_val("x3_prio_bypass0", K_DATA, 0, 32'h5555FFFF);
    expect_val("x3_prio_bypass1", K_DATA, 1, 32'h5555FFFF);
    check(); cycle();

    rd(0, 3); rsv(10);
    expect_val("x3_prio_stored", K_DATA, 0, 32'h5555FFFF);
    check(); cycle();

    // Scoreboard lifecycle on x10
    rd(0, 10); rd(1, 10);
    expect_val("x10_busy_set", K_BUSY, 1, 32'h1);
    expect_val("x10_any_set",  K_ANY,  0, 32'h1);
    check();
    wr(0, 10, 32'h42, 1'b1);
    expect_val("x10_clr_bypass", K_BUSY, 0, 32'h0);
    expect_val("x10_data_bypass", K_DATA, 0, 32'h42);
    expect_val("x10_any_no_bypass", K_ANY, 0, 32'h1);
    check(); cycle();

    rd(0, 10);
    expect_val("x10_busy_cleared", K_BUSY, 0, 32'h0);
    expect_val("x10_data_stored",  K_DATA, 0, 32'h42);
    expect_val("x10_any_cleared",  K_ANY,  0, 32'h0);
    check(); rsv(12); cycle();

    // Reserve vs clear collision on x12
    rd(0, 12);
    expect_val("x12_busy_before", K_BUSY, 0, 32'h1);
    check();
    rsv(12); wr(1, 12, 32'h99, 1'b1);
    expect_val("x12_clr_bypass", K_BUSY, 0, 32'h0);
    expect_val("x12_data_bypass", K_DATA, 0, 32'h99);
    check(); cycle();

    rd(0, 12);
    expect_val("x12_rsv_wins", K_BUSY, 0, 32'h1);
    expect_val("x12_data",     K_DATA, 0, 32'h99);
    check();
    // Non-final write: data changes, busy held
    wr(0, 12, 32'h77, 1'b0);
    expect_val("x12_nonfinal_busy", K_BUSY, 0, 32'h1);
    check(); cycle();

    rd(0, 12); rd(1, 1);
    expect_val("x12_nonfinal_data", K_DATA, 0, 32'h77);
    expect_val("x12_nonfinal_held", K_BUSY, 0, 32'h1);
    check();
    // Flush scenario: give x1 a value and reserve it
    wr(0, 1, 32'h11111111, 1'b0); rsv(1);
    expect_val("x1_bypass",   K_DATA, 1, 32'h11111111);
    expect_val("x1_rsv_late", K_BUSY, 1, 32'h0);
    check(); cycle();

    rd(1, 1); rsv(2);
    expect_val("x1_busy", K_BUSY, 1, 32'h1);
    check(); cycle();

    rsv(4); cycle();

    rd(0, 4); flush = 1'b1; rsv(8);
    expect_val("x4_busy_pre_flush", K_BUSY, 0, 32'h1);
    check(); cycle();

    rd(0, 8); rd(1, 1);
    expect_val("x8_busy_after_flush", K_BUSY, 0, 32'h1);
    expect_val("x1_busy_after_flush", K_BUSY, 1, 32'h0);
    expect_val("x1_data_kept",        K_DATA, 1, 32'h11111111);
    expect_val("any_after_flush",     K_ANY,  0, 32'h1);
    check();
    rd(0, 12); rd(1, 2);
    expect_val("x12_flushed", K_BUSY, 0, 32'h0);
    expect_val("x2_flushed",  K_BUSY, 1, 32'h0);
    check();
    rd(1, 4);
    expect_val("x4_flushed", K_BUSY, 1, 32'h0);
    check();

    // Two ports on x8, only the lower one final; reserve of x0 is a no-op
    rd(0, 8); rd(1, 0);
    wr(0, 8, 32'h1, 1'b1); wr(1, 8, 32'h2, 1'b0); rsv(0);
    expect_val("x8_multi_clr_bypass", K_BUSY, 0, 32'h0);
    expect_val("x8_multi_data_bypass", K_DATA, 0, 32'h2);
    check(); cycle();

    rd(0, 8);
    expect_val("x8_multi_data", K_DATA, 0, 32'h2);
    expect_val("x8_multi_busy", K_BUSY, 0, 32'h0);
    expect_val("rsv_x0_noop",   K_ANY,  0, 32'h0);
    check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reg_file_mp_sb
